lec_miter_monitor: RTL and testbench
====================================

Name: lec_miter_monitor

Overview:
- Sequential miter that compares golden and revised output vectors of an equivalence-test case, one vector per accepted beat.
- Sits after the two design instances in a simulation or emulation harness.
- Counts vectors and mismatches, raises a sticky fail flag, and buffers mismatch records in a small FIFO for readout.
- Generalises a fixed 9-output, all-constant test case to any output width, with per-bit masking and a stop-on-fail mode.

Parameters:
N_OUT, 9, compared output bits per vector
CNT_W, 16, width of vector and mismatch counters (saturating)
DEPTH, 4, mismatch-record FIFO depth (power of 2, >=2)
STOP_ON_FAIL, 0, 1 = stop accepting vectors after first mismatch

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: clear counters/FIFO/flags, enter RUN
finish  in  1  one-cycle pulse: enter DONE
in_valid  in  1  vector present
in_ready  out  1  vector accepted when in_valid & in_ready
gold  in  N_OUT  golden outputs
rev  in  N_OUT  revised outputs
mask  in  N_OUT  1 = bit compared, 0 = ignored
busy  out  1  state is RUN
fail  out  1  sticky: any mismatch since start
done  out  1  state is DONE
vec_cnt  out  CNT_W  accepted vectors
mis_cnt  out  CNT_W  mismatching vectors
ovf  out  1  sticky: record dropped because FIFO full
rec_valid  out  1  FIFO not empty
rec_ready  in  1  consumer pop
rec_idx  out  CNT_W  vector index of head record
rec_diff  out  N_OUT  (gold^rev)&mask of head record

Behaviour:
- Clock: single clock clk. Reset: asynchronous, active-low rst_n, applied any time.
- Reset values: state IDLE; all outputs 0; FIFO empty.
- States: IDLE -> RUN on start. RUN -> HALT on the first mismatch when STOP_ON_FAIL=1. RUN or HALT -> DONE on finish. DONE or HALT -> RUN on start, which also clears everything. start in RUN re-clears and stays in RUN.
- in_ready = (state==RUN), combinational from state.
- Accept = in_valid & in_ready.
- diff = (gold ^ rev) & mask; a mismatch is diff != 0.
- On accept, registered with 1-cycle latency:
  - vec_cnt += 1.
  - If mismatch: mis_cnt += 1, fail = 1, push {vec_cnt pre-increment, diff}.
- Counters saturate at all-ones; they do not wrap.
- FIFO push when full: record dropped, ovf = 1, counters still update.
- Pop on rec_valid & rec_ready. Simultaneous push and pop when full is allowed: no drop, occupancy unchanged.
- rec_idx and rec_diff are registered FIFO-head values, stable while rec_valid & !rec_ready.
- start and accept in the same cycle: start wins; the vector is ignored and counters read 0.
- finish and accept in the same cycle: the vector is counted, then DONE.
- start and finish together: start wins.
- STOP_ON_FAIL=1: in_ready drops the cycle after the failing vector is accepted.
- In HALT and DONE, counters and flags hold. FIFO pops continue.
- Reset mid-operation: everything cleared immediately; no partial record survives.

Optional Feature:
- Macro: LEC_MITER_FIRST_FAIL_EN.
- Defined: adds outputs ff_valid (1), ff_idx (CNT_W) and ff_bit ($clog2(N_OUT)).
  - On the first mismatch after start, latch the vector index and the lowest set bit of diff, and set ff_valid.
  - Held until start or reset; later mismatches never overwrite.
  - These outputs are unaffected by FIFO overflow.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Reset, start, 10 vectors with gold==rev, mask all-ones, then finish -> vec_cnt=10, mis_cnt=0, fail=0, rec_valid=0, done=1.
- Vector 3 has gold=9'h000, rev=9'h041, mask=9'h1FF -> fail=1, mis_cnt=1, record {idx=3, diff=9'h041}. With LEC_MITER_FIRST_FAIL_EN: ff_idx=3, ff_bit=0.
- Same mismatch with mask=9'h1BE -> no fail, mis_cnt=0 (both differing bits masked).
- DEPTH=4, rec_ready=0, 6 mismatching vectors -> 4 records held (idx 0..3), ovf=1, mis_cnt=6. Then pop all -> idx order 0,1,2,3.
- STOP_ON_FAIL=1, in_valid held high, mismatch at vector 5 -> in_ready=0 from the following cycle, vec_cnt=6, state HALT. start -> counters 0, busy=1.
- rst_n asserted low mid-RUN with 2 records queued -> all outputs 0 asynchronously. After release: state IDLE, in_ready=0 until start.

Source files
------------

// File: rtl/lec_miter_monitor.sv
// Sequential miter: compares masked golden/revised vectors, counts them,
// flags failures and queues mismatch records {index, diff} for readout.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, finish         pulses: clear+RUN, enter DONE
//   in_valid/in_ready     vector handshake (ready = state RUN)
//   gold, rev, mask       compared vectors, 1 in mask = compare bit
//   busy, done, fail      state RUN, state DONE, sticky mismatch
//   vec_cnt, mis_cnt      saturating vector / mismatch counters
//   ovf                   sticky: mismatch record dropped on full FIFO
//   rec_valid/rec_ready   record FIFO pop handshake
//   rec_idx, rec_diff     head record contents
//   ff_valid/ff_idx/ff_bit  first-fail capture, only with
//                           LEC_MITER_FIRST_FAIL_EN defined
module lec_miter_monitor #(
  parameter int N_OUT        = 9,
  parameter int CNT_W        = 16,
  parameter int DEPTH        = 4,
  parameter int STOP_ON_FAIL = 0,
  localparam int FB_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef LEC_MITER_FIRST_FAIL_EN
  output logic             ff_valid,
  output logic [CNT_W-1:0] ff_idx,
  output logic [FB_W-1:0]  ff_bit,
`endif
  input  logic             start,
  input  logic             finish,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_OUT-1:0] gold,
  input  logic [N_OUT-1:0] rev,
  input  logic [N_OUT-1:0] mask,
  output logic             busy,
  output logic             fail,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] mis_cnt,
  output logic             ovf,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [CNT_W-1:0] rec_idx,
  output logic [N_OUT-1:0] rec_diff
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] mis_q, mis_d;
  logic             fail_q, fail_d;
  logic             ovf_q, ovf_d;

  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [CNT_W-1:0] mem_idx_q [DEPTH];
  logic [N_OUT-1:0] mem_diff_q [DEPTH];

  logic [N_OUT-1:0] diff;
  logic             mism;
  logic             run;
  logic             acc;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_req;
  logic             push;
  logic             drop;

  // start overrides any same-cycle accept or pop: the cycle is a clear.
  always_comb begin
    diff     = (gold ^ rev) & mask;
    mism     = |diff;
    run      = (state_q == S_RUN);
    acc      = in_valid & run & ~start;
    full     = (cnt_q == CW'(DEPTH));
    empty    = (cnt_q == '0);
    pop      = rec_ready & ~empty & ~start;
    push_req = acc & mism;
    // a pop in the same cycle frees the slot for a push into a full FIFO
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    mis_d   = mis_q;
    fail_d  = fail_q;
    ovf_d   = ovf_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (start) begin
      state_d = S_RUN;
      vec_d   = '0;
      mis_d   = '0;
      fail_d  = 1'b0;
      ovf_d   = 1'b0;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
    end else begin
      if (acc && vec_q != '1) begin
        vec_d = vec_q + CNT_W'(1);
      end
      if (push_req) begin
        fail_d = 1'b1;
        if (mis_q != '1) begin
          mis_d = mis_q + CNT_W'(1);
        end
      end
      if (drop) begin
        ovf_d = 1'b1;
      end
      if (push) begin
        wr_d = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
      unique case (state_q)
        S_RUN: begin
          if (finish) begin
            state_d = S_DONE;
          end else if (push_req && STOP_ON_FAIL != 0) begin
            state_d = S_HALT;
          end
        end
        S_HALT: begin
          if (finish) begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      mis_q   <= '0;
      fail_q  <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      mis_q   <= mis_d;
      fail_q  <= fail_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // record index is the pre-increment vector count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_idx_q[i]  <= '0;
        mem_diff_q[i] <= '0;
      end
    end else if (push) begin
      mem_idx_q[wr_q]  <= vec_q;
      mem_diff_q[wr_q] <= diff;
    end
  end

`ifdef LEC_MITER_FIRST_FAIL_EN
  logic             ffv_q, ffv_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [FB_W-1:0]  ffb_q, ffb_d;
  logic [FB_W-1:0]  low_bit;

  // scan from the top so the lowest set bit is the last one written
  always_comb begin
    low_bit = '0;
    for (int i = N_OUT - 1; i >= 0; i--) begin
      if (diff[i]) begin
        low_bit = FB_W'(i);
      end
    end
  end

  always_comb begin
    ffv_d = ffv_q;
    ffi_d = ffi_q;
    ffb_d = ffb_q;
    if (start) begin
      ffv_d = 1'b0;
      ffi_d = '0;
      ffb_d = '0;
    end else if (push_req && !ffv_q) begin
      ffv_d = 1'b1;
      ffi_d = vec_q;
      ffb_d = low_bit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ffv_q <= 1'b0;
      ffi_q <= '0;
      ffb_q <= '0;
    end else begin
      ffv_q <= ffv_d;
      ffi_q <= ffi_d;
      ffb_q <= ffb_d;
    end
  end

  assign ff_valid = ffv_q;
  assign ff_idx   = ffi_q;
  assign ff_bit   = ffb_q;
`else
  // first-fail capture not built
`endif

  assign in_ready  = run;
  assign busy      = run;
  assign done      = (state_q == S_DONE);
  assign fail      = fail_q;
  assign vec_cnt   = vec_q;
  assign mis_cnt   = mis_q;
  assign ovf       = ovf_q;
  assign rec_valid = ~empty;
  // stale entries never leak out while the FIFO is empty
  assign rec_idx   = empty ? '0 : mem_idx_q[rd_q];
  assign rec_diff  = empty ? '0 : mem_diff_q[rd_q];

endmodule

// File: tb/tb_lec_miter_monitor.sv
// Testbench for lec_miter_monitor: directed vector table plus
// hand-written stop-on-fail, saturation and async reset sequences.
module tb_lec_miter_monitor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start, finish, in_valid, rec_ready;
  logic [8:0] gold, rev, mask;
  logic in_ready, busy, fail, done, ovf, rec_valid;
  logic [15:0] vec_cnt, mis_cnt, rec_idx;
  logic [8:0] rec_diff;

  logic s_start, s_finish, s_valid;
  logic s_ready, s_busy, s_fail, s_done, s_ovf, s_rv;
  logic [2:0] s_vec, s_mis, s_idx;
  logic [8:0] s_diff;

`ifdef LEC_MITER_FIRST_FAIL_EN
  logic ff_valid, s_ff_valid;
  logic [15:0] ff_idx;
  logic [2:0] s_ff_idx;
  logic [3:0] ff_bit, s_ff_bit;
`endif

  lec_miter_monitor dut (
    .clk(clk), .rst_n(rst_n),
`ifdef LEC_MITER_FIRST_FAIL_EN
    .ff_valid(ff_valid), .ff_idx(ff_idx), .ff_bit(ff_bit),
`endif
    .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready),
    .gold(gold), .rev(rev), .mask(mask),
    .busy(busy), .fail(fail), .done(done),
    .vec_cnt(vec_cnt), .mis_cnt(mis_cnt), .ovf(ovf),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_idx(rec_idx), .rec_diff(rec_diff)
  );

  lec_miter_monitor #(.CNT_W(3), .STOP_ON_FAIL(1)) dut_s (
    .clk(clk), .rst_n(rst_n),
`ifdef LEC_MITER_FIRST_FAIL_EN
    .ff_valid(s_ff_valid), .ff_idx(s_ff_idx), .ff_bit(s_ff_bit),
`endif
    .start(s_start), .finish(s_finish),
    .in_valid(s_valid), .in_ready(s_ready),
    .gold(gold), .rev(rev), .mask(mask),
    .busy(s_busy), .fail(s_fail), .done(s_done),
    .vec_cnt(s_vec), .mis_cnt(s_mis), .ovf(s_ovf),
    .rec_valid(s_rv), .rec_ready(rec_ready),
    .rec_idx(s_idx), .rec_diff(s_diff)
  );

  typedef struct {
    logic st, fin, v, rr;
    logic [8:0] g, r, m;
    logic [15:0] evec, emis;
    logic efail, erv, ebusy, edone, eovf;
    logic [15:0] eidx;
    logic [8:0] ediff;
    logic cff, effv;
    logic [15:0] effi;
    logic [3:0] effb;
  } row_t;

  row_t tbl[$];
  row_t rw;
  int n_vec = 0;
  int n_mis = 0;

  function automatic row_t mk(
    input logic st, fin, v, rr,
    input logic [8:0] g, r, m,
    input int vec, mis,
    input logic fl, rv, bz, dn, ov,
    input int idx,
    input logic [8:0] df);
    row_t x;
    x.st = st; x.fin = fin; x.v = v; x.rr = rr;
    x.g = g; x.r = r; x.m = m;
    x.evec = 16'(vec); x.emis = 16'(mis);
    x.efail = fl; x.erv = rv; x.ebusy = bz;
    x.edone = dn; x.eovf = ov;
    x.eidx = 16'(idx); x.ediff = df;
    x.cff = 1'b0; x.effv = 1'b0;
    x.effi = '0; x.effb = '0;
    return x;
  endfunction

  task automatic chk(input string nm, input int i,
                     input logic [31:0] a, input logic [31:0] e);
    n_vec++;
    if (a !== e) begin
      n_mis++;
      $display("FAIL %s step %0d: got %0h want %0h", nm, i, a, e);
    end
  endtask

  task automatic chk_main_zero(input int i);
    chk("rst_vec", i, 32'(vec_cnt), 0);
    chk("rst_mis", i, 32'(mis_cnt), 0);
    chk("rst_fail", i, 32'(fail), 0);
    chk("rst_busy", i, 32'(busy), 0);
    chk("rst_done", i, 32'(done), 0);
    chk("rst_ovf", i, 32'(ovf), 0);
    chk("rst_ready", i, 32'(in_ready), 0);
    chk("rst_rv", i, 32'(rec_valid), 0);
    chk("rst_idx", i, 32'(rec_idx), 0);
    chk("rst_diff", i, 32'(rec_diff), 0);
`ifdef LEC_MITER_FIRST_FAIL_EN
    chk("rst_ffv", i, 32'(ff_valid), 0);
    chk("rst_ffi", i, 32'(ff_idx), 0);
`endif
  endtask

  localparam logic [8:0] F = 9'h1FF;

  initial begin
    // T1: 10 matching vectors then finish
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,0,1,0,0, 0,0));
    for (int k = 0; k < 10; k++) begin
      tbl.push_back(mk(0,0,1,0, 9'(k*37+5), 9'(k*37+5), F,
                       k+1,0, 0,0,1,0,0, 0,0));
    end
    tbl.push_back(mk(0,1,0,0, 0,0,0, 10,0, 0,0,0,1,0, 0,0));
    // T2: mismatch on vector 3
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,0,1,0,0, 0,0));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0,0,1,0, 9'h0AA,9'h0AA,F,
                       k+1,0, 0,0,1,0,0, 0,0));
    end
    rw = mk(0,0,1,0, 9'h000,9'h041,F, 4,1, 1,1,1,0,0, 3,9'h041);
    rw.cff = 1; rw.effv = 1; rw.effi = 3; rw.effb = 0;
    tbl.push_back(rw);
    tbl.push_back(mk(0,0,0,1, 0,0,0, 4,1, 1,0,1,0,0, 0,0));
    // T3: same mismatch fully masked
    rw = mk(1,0,0,0, 0,0,0, 0,0, 0,0,1,0,0, 0,0);
    rw.cff = 1;
    tbl.push_back(rw);
    tbl.push_back(mk(0,0,1,0, 9'h000,9'h041,9'h1BE,
                     1,0, 0,0,1,0,0, 0,0));
    // T4: FIFO overflow, ordering, push+pop while full
    tbl.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,0,1,0,0, 0,0));
    for (int k = 0; k < 6; k++) begin
      tbl.push_back(mk(0,0,1,0, 9'h000,9'(k+1),F,
                       k+1,k+1, 1,1,1,0,(k >= 4), 0,9'h001));
    end
    tbl.push_back(mk(0,0,0,1, 0,0,0, 6,6, 1,1,1,0,1, 1,9'h002));
    tbl.push_back(mk(0,0,1,0, 0,9'h010,F, 7,7, 1,1,1,0,1, 1,9'h002));
    rw = mk(0,0,1,1, 0,9'h020,F, 8,8, 1,1,1,0,1, 2,9'h003);
    rw.cff = 1; rw.effv = 1; rw.effi = 0; rw.effb = 0;
    tbl.push_back(rw);
    tbl.push_back(mk(0,0,0,1, 0,0,0, 8,8, 1,1,1,0,1, 3,9'h004));
    tbl.push_back(mk(0,0,0,1, 0,0,0, 8,8, 1,1,1,0,1, 6,9'h010));
    tbl.push_back(mk(0,0,0,1, 0,0,0, 8,8, 1,1,1,0,1, 7,9'h020));
    tbl.push_back(mk(0,0,0,1, 0,0,0, 8,8, 1,0,1,0,1, 0,0));
    // T5: finish with accept, DONE behaviour
    tbl.push_back(mk(0,1,1,0, 0,9'h001,F, 9,9, 1,1,0,1,1, 8,9'h001));
    tbl.push_back(mk(0,0,0,1, 0,0,0, 9,9, 1,0,0,1,1, 0,0));
    tbl.push_back(mk(0,0,1,0, 0,9'h001,F, 9,9, 1,0,0,1,1, 0,0));
    // T6: start priority, first-fail hold
    tbl.push_back(mk(1,0,1,0, 0,9'h001,F, 0,0, 0,0,1,0,0, 0,0));
    tbl.push_back(mk(1,1,0,0, 0,0,0, 0,0, 0,0,1,0,0, 0,0));
    rw = mk(0,0,1,0, 0,9'h0C0,F, 1,1, 1,1,1,0,0, 0,9'h0C0);
    rw.cff = 1; rw.effv = 1; rw.effi = 0; rw.effb = 6;
    tbl.push_back(rw);
    rw = mk(0,0,1,0, 0,9'h001,F, 2,2, 1,1,1,0,0, 0,9'h0C0);
    rw.cff = 1; rw.effv = 1; rw.effi = 0; rw.effb = 6;
    tbl.push_back(rw);

    rst_n = 1'b0;
    start = 0; finish = 0; in_valid = 0; rec_ready = 0;
    s_start = 0; s_finish = 0; s_valid = 0;
    gold = 0; rev = 0; mask = 0;
    repeat (2) @(negedge clk);
    chk_main_zero(-1);
    chk("rst_s_ready", -1, 32'(s_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", -1, 32'(busy), 0);
    chk("idle_ready", -1, 32'(in_ready), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; finish = tbl[i].fin;
      in_valid = tbl[i].v; rec_ready = tbl[i].rr;
      gold = tbl[i].g; rev = tbl[i].r; mask = tbl[i].m;
      @(negedge clk);
      chk("vec_cnt", i, 32'(vec_cnt), 32'(tbl[i].evec));
      chk("mis_cnt", i, 32'(mis_cnt), 32'(tbl[i].emis));
      chk("fail", i, 32'(fail), 32'(tbl[i].efail));
      chk("rec_valid", i, 32'(rec_valid), 32'(tbl[i].erv));
      chk("busy", i, 32'(busy), 32'(tbl[i].ebusy));
      chk("in_ready", i, 32'(in_ready), 32'(tbl[i].ebusy));
      chk("done", i, 32'(done), 32'(tbl[i].edone));
      chk("ovf", i, 32'(ovf), 32'(tbl[i].eovf));
      chk("rec_idx", i, 32'(rec_idx), 32'(tbl[i].eidx));
      chk("rec_diff", i, 32'(rec_diff), 32'(tbl[i].ediff));
`ifdef LEC_MITER_FIRST_FAIL_EN
      if (tbl[i].cff) begin
        chk("ff_valid", i, 32'(ff_valid), 32'(tbl[i].effv));
        chk("ff_idx", i, 32'(ff_idx), 32'(tbl[i].effi));
        chk("ff_bit", i, 32'(ff_bit), 32'(tbl[i].effb));
      end
`endif
    end
    start = 0; finish = 0; in_valid = 0; rec_ready = 0;

    // stop-on-fail with in_valid held, then counter saturation
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    chk("s_busy_start", 100, 32'(s_busy), 1);
    s_valid = 1; gold = 0; rev = 0; mask = F;
    repeat (5) @(negedge clk);
    chk("s_vec5", 101, 32'(s_vec), 5);
    chk("s_ready5", 101, 32'(s_ready), 1);
    rev = 9'h003;
    @(negedge clk);
    rev = 9'h000;
    chk("s_vec6", 102, 32'(s_vec), 6);
    chk("s_mis", 102, 32'(s_mis), 1);
    chk("s_fail", 102, 32'(s_fail), 1);
    chk("s_ready_halt", 102, 32'(s_ready), 0);
    chk("s_busy_halt", 102, 32'(s_busy), 0);
    chk("s_done_halt", 102, 32'(s_done), 0);
    chk("s_rec_idx", 102, 32'(s_idx), 5);
    chk("s_rec_diff", 102, 32'(s_diff), 3);
    repeat (2) @(negedge clk);
    chk("s_vec_hold", 103, 32'(s_vec), 6);
    chk("s_ready_hold", 103, 32'(s_ready), 0);
    s_start = 1;
    @(negedge clk);
    s_start = 0;
    chk("s_vec_clr", 104, 32'(s_vec), 0);
    chk("s_fail_clr", 104, 32'(s_fail), 0);
    chk("s_busy_rst", 104, 32'(s_busy), 1);
    chk("s_rv_clr", 104, 32'(s_rv), 0);
    repeat (10) @(negedge clk);
    chk("s_vec_sat", 105, 32'(s_vec), 7);
    chk("s_mis_sat", 105, 32'(s_mis), 0);
    s_valid = 0; s_finish = 1;
    @(negedge clk);
    s_finish = 0;
    chk("s_done", 106, 32'(s_done), 1);
    chk("s_vec_done", 106, 32'(s_vec), 7);

    // async reset mid-run with two records queued
    start = 1;
    @(negedge clk);
    start = 0; in_valid = 1; gold = 0; rev = 9'h005; mask = F;
    repeat (2) @(negedge clk);
    in_valid = 0;
    chk("pre_rst_rv", 107, 32'(rec_valid), 1);
    chk("pre_rst_vec", 107, 32'(vec_cnt), 2);
    #2 rst_n = 1'b0;
    #1 chk_main_zero(108);
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1;
    @(negedge clk);
    chk("post_rst_busy", 109, 32'(busy), 0);
    chk("post_rst_ready", 109, 32'(in_ready), 0);
    chk("post_rst_vec", 109, 32'(vec_cnt), 0);
    in_valid = 0; start = 1;
    @(negedge clk);
    start = 0;
    chk("post_rst_start", 110, 32'(busy), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
